wb_queue: RTL and testbench

Writeback arbiter and buffer for the register-file write port. It merges two writers onto the single write port (`we3`/`a3`/`wd3`): the in-order pipeline writeback port, which has priority, and a queued port for variable-latency units such as load and mul/div. It also exposes pending-write lookups with forwarding data for the two read addresses, so decode can bypass or stall on in-flight results.

---
 rtl/wb_queue.sv | 129 ++++++++++++
 tb/tb_wb_queue.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_queue.sv
// Writeback arbiter for the register-file write port: the pipeline port has priority,
// variable-latency results wait in a small FIFO with squash and forwarding lookups.
module wb_queue #(
    parameter int ADDRESS_WIDTH = 5,
    parameter int DATA_WIDTH    = 32,
    parameter int DEPTH         = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       pri_we,
    input  logic [ADDRESS_WIDTH-1:0]   pri_addr,
    input  logic [DATA_WIDTH-1:0]      pri_data,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [ADDRESS_WIDTH-1:0]   in_addr,
    input  logic [DATA_WIDTH-1:0]      in_data,
    output logic                       we3,
    output logic [ADDRESS_WIDTH-1:0]   a3,
    output logic [DATA_WIDTH-1:0]      wd3,
    input  logic [ADDRESS_WIDTH-1:0]   a1,
    input  logic [ADDRESS_WIDTH-1:0]   a2,
    output logic                       pend1,
    output logic                       pend2,
    output logic [DATA_WIDTH-1:0]      fwd1,
    output logic [DATA_WIDTH-1:0]      fwd2,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [PW-1:0]            wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]            rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]            count_q, count_d;
    logic [DEPTH-1:0]         live_q, live_d;
    logic [ADDRESS_WIDTH-1:0] addr_q [DEPTH];
    logic [DATA_WIDTH-1:0]    data_q [DEPTH];

    logic push;
    logic pop;
    logic head_live;

    assign in_ready  = (count_q != CW'(DEPTH));
    assign push      = in_valid && in_ready && (in_addr != '0);
    assign pop       = !pri_we && (count_q != '0);
    assign head_live = live_q[rd_ptr_q];
    assign count     = count_q;

    always_comb begin
        we3 = 1'b0;
        a3  = '0;
        wd3 = '0;
        if (pri_we) begin
            we3 = 1'b1;
            a3  = pri_addr;
            wd3 = pri_data;
        end else if (pop && head_live) begin
            we3 = 1'b1;
            a3  = addr_q[rd_ptr_q];
            wd3 = data_q[rd_ptr_q];
        end
    end

    // live is cleared on pop, so a set live bit always marks an occupied entry
    always_comb begin
        live_d   = live_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        if (pri_we && (pri_addr != '0)) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (addr_q[i] == pri_addr) begin
                    live_d[i] = 1'b0;
                end
            end
        end
        if (pop) begin
            live_d[rd_ptr_q] = 1'b0;
            rd_ptr_d         = rd_ptr_q + PW'(1);
        end
        if (push) begin
            live_d[wr_ptr_q] = 1'b1;
            wr_ptr_d         = wr_ptr_q + PW'(1);
        end
        count_d = count_q + CW'(push) - CW'(pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            live_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            live_q   <= live_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            addr_q[wr_ptr_q] <= in_addr;
            data_q[wr_ptr_q] <= in_data;
        end
    end

    // Scan oldest to youngest so the last match is the youngest entry
    always_comb begin
        logic [PW-1:0] idx;
        idx   = '0;
        pend1 = 1'b0;
        pend2 = 1'b0;
        fwd1  = '0;
        fwd2  = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = rd_ptr_q + PW'(k);
            if (live_q[idx] && (addr_q[idx] == a1) && (a1 != '0)) begin
                pend1 = 1'b1;
                fwd1  = data_q[idx];
            end
            if (live_q[idx] && (addr_q[idx] == a2) && (a2 != '0)) begin
                pend2 = 1'b1;
                fwd2  = data_q[idx];
            end
        end
    end

endmodule

// File: tb/tb_wb_queue.sv
// Bench for wb_queue: directed scenarios plus random traffic, checked against a
// queue-of-entries reference model evaluated every cycle.
module tb_wb_queue;

    localparam int AW = 5;
    localparam int DW = 32;
    localparam int D  = 4;

    logic          clk;
    logic          rst_n;
    logic          pri_we;
    logic [AW-1:0] pri_addr;
    logic [DW-1:0] pri_data;
    logic          in_valid;
    logic          in_ready;
    logic [AW-1:0] in_addr;
    logic [DW-1:0] in_data;
    logic          we3;
    logic [AW-1:0] a3;
    logic [DW-1:0] wd3;
    logic [AW-1:0] a1;
    logic [AW-1:0] a2;
    logic          pend1;
    logic          pend2;
    logic [DW-1:0] fwd1;
    logic [DW-1:0] fwd2;
    logic [$clog2(D):0] count;

    wb_queue #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(D)) dut (
        .clk(clk), .rst_n(rst_n),
        .pri_we(pri_we), .pri_addr(pri_addr), .pri_data(pri_data),
        .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr), .in_data(in_data),
        .we3(we3), .a3(a3), .wd3(wd3),
        .a1(a1), .a2(a2), .pend1(pend1), .pend2(pend2), .fwd1(fwd1), .fwd2(fwd2),
        .count(count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit            live;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } ent_t;

    ent_t mq[$];
    int   n_vec  = 0;
    int   n_miss = 0;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic lookup(input logic [AW-1:0] a, output logic p, output logic [DW-1:0] d);
        p = 1'b0;
        d = '0;
        if (a != '0) begin
            foreach (mq[i]) begin
                if (mq[i].live && mq[i].addr == a) begin
                    p = 1'b1;
                    d = mq[i].data;
                end
            end
        end
    endtask

    task automatic drive(input logic pw, input logic [AW-1:0] pa, input logic [DW-1:0] pd,
                         input logic iv, input logic [AW-1:0] ia, input logic [DW-1:0] id,
                         input logic [AW-1:0] x1, input logic [AW-1:0] x2);
        pri_we = pw; pri_addr = pa; pri_data = pd;
        in_valid = iv; in_addr = ia; in_data = id;
        a1 = x1; a2 = x2;
    endtask

    task automatic sample();
        logic          ew;
        logic [AW-1:0] ea;
        logic [DW-1:0] ed;
        bit            check_ad;
        logic          p;
        logic [DW-1:0] d;
        @(negedge clk);
        ew = 1'b0; ea = '0; ed = '0; check_ad = 1;
        if (pri_we) begin
            ew = 1'b1; ea = pri_addr; ed = pri_data;
        end else if (mq.size() != 0) begin
            if (mq[0].live) begin
                ew = 1'b1; ea = mq[0].addr; ed = mq[0].data;
            end else begin
                check_ad = 0;
            end
        end
        chk("we3", DW'(we3), DW'(ew));
        if (check_ad) begin
            chk("a3", DW'(a3), DW'(ea));
            chk("wd3", wd3, ed);
        end
        chk("in_ready", DW'(in_ready), DW'(mq.size() != D));
        chk("count", DW'(count), DW'(mq.size()));
        lookup(a1, p, d);
        chk("pend1", DW'(pend1), DW'(p));
        chk("fwd1", fwd1, d);
        lookup(a2, p, d);
        chk("pend2", DW'(pend2), DW'(p));
        chk("fwd2", fwd2, d);
    endtask

    task automatic advance();
        bit   rdy;
        ent_t e;
        @(posedge clk);
        if (rst_n) begin
            rdy = (mq.size() != D);
            if (pri_we && pri_addr != '0) begin
                for (int i = 0; i < mq.size(); i++) begin
                    if (mq[i].addr == pri_addr) begin
                        e = mq[i]; e.live = 0; mq[i] = e;
                    end
                end
            end
            if (!pri_we && mq.size() != 0) void'(mq.pop_front());
            if (in_valid && rdy && in_addr != '0) begin
                e.live = 1; e.addr = in_addr; e.data = in_data;
                mq.push_back(e);
            end
        end else begin
            mq.delete();
        end
        #1;
    endtask

    task automatic step(input logic pw, input logic [AW-1:0] pa, input logic [DW-1:0] pd,
                        input logic iv, input logic [AW-1:0] ia, input logic [DW-1:0] id,
                        input logic [AW-1:0] x1, input logic [AW-1:0] x2);
        drive(pw, pa, pd, iv, ia, id, x1, x2);
        sample();
        advance();
    endtask

    initial begin
        int pushed;
        int guard;
        bit acc;

        // reset with a queued request presented
        rst_n = 1'b0;
        drive(0, 0, 0, 1, 5, 'h11, 5, 0);
        sample();
        chk("rst_we3", DW'(we3), 0);
        chk("rst_count", DW'(count), 0);
        chk("rst_ready", DW'(in_ready), 1);
        chk("rst_pend1", DW'(pend1), 0);
        advance();
        drive(1, 3, 'h77, 1, 5, 'h11, 5, 0);
        sample();
        chk("rst_pri_we3", DW'(we3), 1);
        chk("rst_pri_a3", DW'(a3), 3);
        advance();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        #2 rst_n = 1'b1;
        mq.delete();

        // first enqueue after reset
        step(0, 0, 0, 1, 5, 'h11, 5, 0);
        drive(0, 0, 0, 0, 0, 0, 5, 0);
        sample();
        chk("first_we3", DW'(we3), 1);
        chk("first_a3", DW'(a3), 5);
        chk("first_wd3", wd3, 'h11);
        chk("first_pend1", DW'(pend1), 1);
        advance();
        drive(0, 0, 0, 0, 0, 0, 5, 0);
        sample();
        chk("first_count", DW'(count), 0);
        chk("first_pend_fall", DW'(pend1), 0);
        advance();

        // primary port holds off the queue
        step(0, 0, 0, 1, 6, 'hAA, 6, 0);
        for (int i = 0; i < 3; i++) begin
            drive(1, 7, 'h55, 0, 0, 0, 6, 0);
            sample();
            chk("prio_a3", DW'(a3), 7);
            chk("prio_count", DW'(count), 1);
            advance();
        end
        drive(0, 0, 0, 0, 0, 0, 6, 0);
        sample();
        chk("prio_drain_a3", DW'(a3), 6);
        chk("prio_drain_wd3", wd3, 'hAA);
        advance();

        // squash of an older queued write
        step(1, 20, 0, 1, 8, 1, 8, 0);
        step(1, 20, 0, 1, 9, 2, 8, 0);
        drive(1, 8, 3, 0, 0, 0, 8, 9);
        sample();
        chk("sq_pend_before", DW'(pend1), 1);
        advance();
        drive(0, 0, 0, 0, 0, 0, 8, 9);
        sample();
        chk("sq_pend_after", DW'(pend1), 0);
        chk("sq_bubble_we3", DW'(we3), 0);
        chk("sq_count", DW'(count), 2);
        advance();
        drive(0, 0, 0, 0, 0, 0, 8, 9);
        sample();
        chk("sq_a3", DW'(a3), 9);
        chk("sq_wd3", wd3, 2);
        advance();

        // forwarding picks the youngest match
        step(1, 20, 0, 1, 4, 'h10, 4, 0);
        step(1, 20, 0, 1, 4, 'h20, 4, 0);
        drive(1, 20, 0, 0, 0, 0, 4, 0);
        sample();
        chk("fwd_pend1", DW'(pend1), 1);
        chk("fwd_fwd1", fwd1, 'h20);
        chk("fwd_pend2", DW'(pend2), 0);
        chk("fwd_fwd2", fwd2, 0);
        advance();
        repeat (3) step(0, 0, 0, 0, 0, 0, 4, 0);

        // x0 enqueue is dropped
        step(0, 0, 0, 1, 0, 'hBEEF, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        sample();
        chk("x0_count", DW'(count), 0);
        chk("x0_we3", DW'(we3), 0);
        advance();

        // same-cycle primary and enqueue to one register
        drive(1, 3, 'h33, 1, 3, 'h44, 3, 0);
        sample();
        chk("same_a3", DW'(a3), 3);
        chk("same_wd3", wd3, 'h33);
        advance();
        drive(0, 0, 0, 0, 0, 0, 3, 0);
        sample();
        chk("same_we3", DW'(we3), 1);
        chk("same_q_wd3", wd3, 'h44);
        chk("same_pend1", DW'(pend1), 1);
        advance();

        // fill, then drain while pushing across the pointer wrap
        for (int i = 0; i < D; i++) step(1, 1, 'h99, 1, AW'(10 + i), DW'('h100 + i), 10, 11);
        drive(1, 1, 'h99, 1, 30, 'hDEAD, 10, 30);
        sample();
        chk("full_ready", DW'(in_ready), 0);
        chk("full_count", DW'(count), D);
        advance();
        pushed = 0;
        guard  = 0;
        while (pushed < 2 * D && guard < 60) begin
            drive(0, 0, 0, 1, AW'(16 + pushed), DW'('h200 + pushed), AW'(16 + pushed), 12);
            acc = (mq.size() != D);
            sample();
            advance();
            if (acc) pushed++;
            guard++;
        end
        chk("wrap_pushed", DW'(pushed), 2 * D);
        repeat (D + 2) step(0, 0, 0, 0, 0, 0, 17, 23);

        // asynchronous reset discards pending entries
        for (int i = 0; i < 3; i++) step(1, 2, 'h5, 1, AW'(12 + i), DW'('h300 + i), 12, 13);
        drive(0, 0, 0, 0, 0, 0, 12, 13);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_count", DW'(count), 0);
        chk("arst_we3", DW'(we3), 0);
        chk("arst_pend1", DW'(pend1), 0);
        mq.delete();
        @(posedge clk);
        #3 rst_n = 1'b1;

        // random traffic with small address space to force collisions
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 2) == 0), AW'($urandom_range(0, 7)), DW'($urandom),
                 ($urandom_range(0, 1) == 1), AW'($urandom_range(0, 7)), DW'($urandom),
                 AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
